// File: rtl/mistral_pkg.sv
// Shared MLAB constants and a helper that extracts one initial word from a flat INIT vector.
package mistral_pkg;

  localparam int MLAB_ABITS     = 5;
  localparam int MLAB_DBITS     = 20;
  localparam int MLAB_MAX_DBITS = 64;
  localparam int MLAB_INIT_MAXW = MLAB_MAX_DBITS * 256;

  // Word i of an INIT vector laid out as word i = init[i*dbits +: dbits]; bits above dbits read 0.
  function automatic logic [MLAB_MAX_DBITS-1:0] mlab_init_word(
    input logic [MLAB_INIT_MAXW-1:0] init,
    input int                        i,
    input int                        dbits
  );
    logic [MLAB_MAX_DBITS-1:0] w;
    w = '0;
    for (int b = 0; b < MLAB_MAX_DBITS; b++) begin
      if (b < dbits && (i * dbits + b) < MLAB_INIT_MAXW) w[b] = init[i*dbits+b];
    end
    return w;
  endfunction

endpackage

// File: rtl/mistral_mlab_oreg.sv
// Read-data output register: async active-high clear, clock-enabled load.
module mistral_mlab_oreg
  import mistral_pkg::*;
#(
  parameter int DBITS = MLAB_DBITS
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             CE,
  input  logic [DBITS-1:0] D,
  output logic [DBITS-1:0] Q
);

  logic [DBITS-1:0] q_q;
  logic [DBITS-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (CE) q_d = D;
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) q_q <= '0;
    else      q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/mistral_mlab.sv
// Simple dual-port MLAB: one sync write port, one async read port with optional output register.
// Define MISTRAL_MLAB_OUTREG_EN to register B1DATA (one-cycle latency, ARST clears it).
module mistral_mlab
  import mistral_pkg::*;
#(
  parameter int                             ABITS = MLAB_ABITS,
  parameter int                             DBITS = MLAB_DBITS,
  parameter logic [(2**ABITS)*DBITS-1:0]    INIT  = '0
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             CE,
  input  logic [ABITS-1:0] A1ADDR,
  input  logic [DBITS-1:0] A1DATA,
  input  logic             A1EN,
  input  logic [ABITS-1:0] B1ADDR,
  output logic [DBITS-1:0] B1DATA
);

  localparam int DEPTH = 2 ** ABITS;

  // Packed layout makes word i land exactly on INIT[i*DBITS +: DBITS]; no reset, ARST never touches it.
  logic [DEPTH-1:0][DBITS-1:0] mem_q = INIT;
  logic [DBITS-1:0]            rd_word;

  always_ff @(posedge CLK) begin
    if (CE && A1EN) mem_q[A1ADDR] <= A1DATA;
  end

  assign rd_word = mem_q[B1ADDR];

`ifdef MISTRAL_MLAB_OUTREG_EN
  mistral_mlab_oreg #(
    .DBITS (DBITS)
  ) u_oreg (
    .CLK  (CLK),
    .ARST (ARST),
    .CE   (CE),
    .D    (rd_word),
    .Q    (B1DATA)
  );
`else
  logic unused_arst;
  assign unused_arst = ARST;
  assign B1DATA      = rd_word;
`endif

endmodule

// File: tb/tb_mistral_mlab.sv
// Scoreboard bench for mistral_mlab: default 32x20 instance plus a 64x10 instance for the edge addresses.
module tb_mistral_mlab;

  typedef struct {
    string       nm;
    bit          sel;
    logic [19:0] exp;
  } sb_t;

  localparam logic [639:0] INIT_M =
      (640'(20'hABCDE) << (3 * 20))  | (640'(20'h00001) << (9 * 20)) |
      (640'(20'h5A5A5) << (12 * 20)) | (640'(20'h11111) << (1 * 20)) |
      (640'(20'h22222) << (2 * 20));
  localparam logic [639:0] INIT_W = 640'(10'h155) << (62 * 10);

  logic        clk = 1'b0;
  logic        rst, ce, a1en;
  logic [4:0]  a1addr, b1addr;
  logic [19:0] a1data, b1data;
  logic        wce, wen;
  logic [5:0]  waddr, wbaddr;
  logic [9:0]  wdata, wbdata;

  sb_t         sbq[$];
  sb_t         e;
  logic [19:0] act;
  int          n_chk = 0;
  int          n_err = 0;
  event        smp;

  always #5 clk = ~clk;

  mistral_mlab #(.ABITS(5), .DBITS(20), .INIT(INIT_M)) u_dut (
    .CLK(clk), .ARST(rst), .CE(ce), .A1ADDR(a1addr), .A1DATA(a1data),
    .A1EN(a1en), .B1ADDR(b1addr), .B1DATA(b1data)
  );

  mistral_mlab #(.ABITS(6), .DBITS(10), .INIT(INIT_W)) u_wide (
    .CLK(clk), .ARST(rst), .CE(wce), .A1ADDR(waddr), .A1DATA(wdata),
    .A1EN(wen), .B1ADDR(wbaddr), .B1DATA(wbdata)
  );

  // Expected value depends on whether the output register is compiled in.
  function automatic logic [19:0] pick(input logic [19:0] unreg, input logic [19:0] reg_v);
`ifdef MISTRAL_MLAB_OUTREG_EN
    return reg_v;
`else
    return unreg;
`endif
  endfunction

  task automatic push(input string nm, input bit sel, input logic [19:0] exp);
    sb_t s;
    s.nm = nm; s.sel = sel; s.exp = exp;
    sbq.push_back(s);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every negedge (or explicit mid-cycle sample) drains pending expectations.
  initial begin
    forever begin
      @(negedge clk or smp);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = e.sel ? {10'b0, wbdata} : b1data;
        n_chk++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h want %h", e.nm, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ce = 1'b0; a1en = 1'b0; a1addr = '0; a1data = '0; b1addr = 5'd3;
    wce = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; wbaddr = '0;

    cyc(); ce = 1'b1;                 push("rst",      0, pick(20'hABCDE, 20'h0));
    cyc(); rst = 1'b0;                push("rst_rel",  0, pick(20'hABCDE, 20'h0));
    cyc();                            push("init3",    0, 20'hABCDE);
    cyc(); b1addr = 5'd7; a1addr = 5'd7; a1data = 20'h12345; a1en = 1'b1;
                                      push("rdw7_pre", 0, pick(20'h0, 20'hABCDE));
    cyc(); a1en = 1'b0;               push("wr7_new",  0, pick(20'h12345, 20'h0));
    cyc();                            push("wr7_reg",  0, 20'h12345);
    cyc(); ce = 1'b0; a1en = 1'b1; a1data = 20'h54321;
                                      push("ce0_pre",  0, 20'h12345);
    cyc(); a1en = 1'b0; ce = 1'b1;    push("ce0_keep", 0, 20'h12345);
    cyc(); b1addr = 5'd9;             push("rd9",      0, pick(20'h00001, 20'h12345));
    cyc(); a1addr = 5'd9; a1data = 20'hFFFFF; a1en = 1'b1;
                                      push("rd9_reg",  0, 20'h00001);
    cyc(); a1en = 1'b0;               push("rdw9_old", 0, pick(20'hFFFFF, 20'h00001));
    cyc();                            push("rdw9_new", 0, 20'hFFFFF);
    cyc(); b1addr = 5'd12;            push("rd12",     0, pick(20'h5A5A5, 20'hFFFFF));
    cyc();                            push("rd12_reg", 0, 20'h5A5A5);
    // Reset pulse strictly between clock edges.
    @(negedge clk); #2; rst = 1'b1; #1;
    push("arst_async", 0, pick(20'h5A5A5, 20'h0)); ->smp;
    #1; rst = 1'b0;
    cyc();                            push("rd12_after", 0, 20'h5A5A5);
    // Write taken while reset is held, then a write in the cycle reset releases.
    cyc(); rst = 1'b1; a1addr = 5'd13; a1data = 20'h0BEEF; a1en = 1'b1;
                                      push("rst_wr",   0, pick(20'h5A5A5, 20'h0));
    cyc(); rst = 1'b0; a1addr = 5'd14; a1data = 20'h0CAFE; b1addr = 5'd13;
                                      push("wr13_rst", 0, pick(20'h0BEEF, 20'h0));
    cyc(); a1en = 1'b0; b1addr = 5'd14;
                                      push("rd13",     0, pick(20'h0CAFE, 20'h0BEEF));
    cyc();                            push("rd14",     0, 20'h0CAFE);
    cyc(); b1addr = 5'd1;             push("rd1",      0, pick(20'h11111, 20'h0CAFE));
    cyc(); ce = 1'b0; b1addr = 5'd2;  push("ce_hold_a", 0, pick(20'h22222, 20'h11111));
    cyc(); ce = 1'b1;                 push("ce_hold_b", 0, pick(20'h22222, 20'h11111));
    cyc();                            push("ce_rel",   0, 20'h22222);

    // 64x10 instance: extreme addresses and an untouched neighbour.
    cyc(); waddr = 6'd63; wdata = 10'h3FF; wen = 1'b1; wbaddr = 6'd63;
                                      push("w63_pre",  1, 20'h0);
    cyc(); waddr = 6'd0; wdata = 10'h001;
                                      push("w63_new",  1, pick(20'h3FF, 20'h0));
    cyc(); wen = 1'b0;                push("w63_reg",  1, 20'h3FF);
    cyc(); wbaddr = 6'd0;             push("w0",       1, pick(20'h001, 20'h3FF));
    cyc();                            push("w0_reg",   1, 20'h001);
    cyc(); wbaddr = 6'd62;            push("w62",      1, pick(20'h155, 20'h001));
    cyc();                            push("w62_reg",  1, 20'h155);
    cyc(); wbaddr = 6'd1;             push("w1",       1, pick(20'h0, 20'h155));
    cyc();                            push("w1_reg",   1, 20'h0);

    @(negedge clk); #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
